// File: rtl/huffman_decoder_if.sv
// Bundle of the table-load, serial bit and symbol handshake signals.
interface huffman_decoder_if #(
  parameter int unsigned MAXLEN = 8
);
  logic              tbl_valid;
  logic [MAXLEN-1:0] HC1, HC2, HC3, HC4, HC5, HC6;
  logic [MAXLEN-1:0] M1, M2, M3, M4, M5, M6;
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic [2:0]        sym_out;
  logic              sym_valid;
  logic              sym_ready;
  logic              err;
  logic [15:0]       sym_cnt;

  modport master (
    output tbl_valid, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
    output bit_in, bit_valid, sym_ready,
    input  bit_ready, sym_out, sym_valid, err, sym_cnt
  );

  modport slave (
    input  tbl_valid, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
    input  bit_in, bit_valid, sym_ready,
    output bit_ready, sym_out, sym_valid, err, sym_cnt
  );
endinterface

// File: rtl/huffman_decoder.sv
// Serial MSB-first Huffman decoder for a six-symbol code table.
module huffman_decoder #(
  parameter int unsigned MAXLEN = 8
) (
  input logic            clk,
  input logic            reset,
  huffman_decoder_if.slave bus
);

  localparam int unsigned LW = $clog2(MAXLEN) + 1;

  typedef enum logic [1:0] {IDLE, DECODE, OUT, ERR} state_t;

  state_t            state, state_n;
  logic [MAXLEN-1:0] hc [6];
  logic [MAXLEN-1:0] m  [6];
  logic [MAXLEN-1:0] acc, acc_n;
  logic [LW-1:0]     len, len_n;
  logic [2:0]        sym, sym_n;
  logic              vld, vld_n;
  logic              err_q, err_n;
  logic [15:0]       cnt, cnt_n;

  logic [MAXLEN-1:0] shifted;
  logic [LW-1:0]     len_inc;
  logic [MAXLEN-1:0] len_mask;
  logic              hit;
  logic [2:0]        hit_sym;
  logic              accept;

  assign bus.bit_ready = (state == DECODE) && !bus.tbl_valid;
  assign bus.sym_out   = sym;
  assign bus.sym_valid = vld;
  assign bus.err       = err_q;
  assign bus.sym_cnt   = cnt;
  assign accept        = bus.bit_valid && bus.bit_ready;

  // Match the accumulator-plus-incoming-bit against every table entry.
  always_comb begin
    shifted = {acc[MAXLEN-2:0], bus.bit_in};
    len_inc = len + LW'(1);
    for (int unsigned i = 0; i < MAXLEN; i++) begin
      len_mask[i] = (i < 32'(len_inc));
    end
    hit     = 1'b0;
    hit_sym = '0;
    // Scan downward so the lowest-numbered matching symbol is the one kept.
    for (int unsigned k = 6; k > 0; k--) begin
      if ((m[k-1] != '0) && (m[k-1] == len_mask) &&
          ((shifted & m[k-1]) == hc[k-1])) begin
        hit     = 1'b1;
        hit_sym = 3'(k);
      end
    end
  end

  // Next-state and datapath update; a table load overrides every handshake.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    len_n   = len;
    sym_n   = sym;
    vld_n   = vld;
    err_n   = err_q;
    cnt_n   = cnt;
    if (bus.tbl_valid) begin
      acc_n   = '0;
      len_n   = '0;
      vld_n   = 1'b0;
      err_n   = 1'b0;
      cnt_n   = '0;
      state_n = DECODE;
    end else begin
      case (state)
        DECODE: begin
          if (accept) begin
            if (hit) begin
              sym_n   = hit_sym;
              vld_n   = 1'b1;
              acc_n   = '0;
              len_n   = '0;
              state_n = OUT;
            end else if (32'(len_inc) == MAXLEN) begin
              err_n   = 1'b1;
              state_n = ERR;
            end else begin
              acc_n = shifted;
              len_n = len_inc;
            end
          end
        end
        OUT: begin
          if (bus.sym_ready) begin
            vld_n   = 1'b0;
            cnt_n   = cnt + 16'd1;
            state_n = DECODE;
          end
        end
        ERR: begin
          err_n = 1'b1;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      len   <= '0;
      sym   <= '0;
      vld   <= 1'b0;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      len   <= len_n;
      sym   <= sym_n;
      vld   <= vld_n;
      err_q <= err_n;
      cnt   <= cnt_n;
    end
  end

  // Code table capture on a load pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 6; i++) begin
        hc[i] <= '0;
        m[i]  <= '0;
      end
    end else if (bus.tbl_valid) begin
      hc[0] <= bus.HC1;  m[0] <= bus.M1;
      hc[1] <= bus.HC2;  m[1] <= bus.M2;
      hc[2] <= bus.HC3;  m[2] <= bus.M3;
      hc[3] <= bus.HC4;  m[3] <= bus.M4;
      hc[4] <= bus.HC5;  m[4] <= bus.M5;
      hc[5] <= bus.HC6;  m[5] <= bus.M6;
    end
  end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder with a symbol scoreboard.
module tb_huffman_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  huffman_decoder_if #(.MAXLEN(8)) bus ();

  huffman_decoder #(.MAXLEN(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [2:0]  exp_q[$];
  logic [15:0] exp_cnt = '0;
  bit          done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] m6);
    bus.HC1 = 8'h00; bus.M1 = 8'h01;
    bus.HC2 = 8'h02; bus.M2 = 8'h03;
    bus.HC3 = 8'h06; bus.M3 = 8'h07;
    bus.HC4 = 8'h0E; bus.M4 = 8'h0F;
    bus.HC5 = 8'h1E; bus.M5 = 8'h1F;
    bus.HC6 = 8'h1F; bus.M6 = m6;
    bus.tbl_valid = 1'b1;
    tick();
    bus.tbl_valid = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic send_bit(input logic b);
    bit ok = 1'b0;
    bus.bit_in = b;
    bus.bit_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.bit_ready;
      if (!ok) @(posedge clk);
    end
    if (!ok) check("bit_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.bit_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && !bus.sym_valid;
    end
    if (!ok) check("drain_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.tbl_valid = 1'b0;
    bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0;
    bus.sym_ready = 1'b1;
    bus.HC1 = '0; bus.HC2 = '0; bus.HC3 = '0; bus.HC4 = '0; bus.HC5 = '0; bus.HC6 = '0;
    bus.M1 = '0; bus.M2 = '0; bus.M3 = '0; bus.M4 = '0; bus.M5 = '0; bus.M6 = '0;
    fork
      // Monitor: pop and compare on every symbol handshake.
      begin
        while (!done) begin
          @(negedge clk);
          if (bus.sym_valid) check("ready_while_valid", 32'(bus.bit_ready), 32'd0);
          if (bus.sym_valid && bus.sym_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_symbol", 32'(bus.sym_out), 32'd0);
            end else begin
              check("symbol", 32'(bus.sym_out), 32'(exp_q.pop_front()));
            end
          end
        end
      end
      // Stimulus.
      begin
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_sym_valid", 32'(bus.sym_valid), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_bit_ready", 32'(bus.bit_ready), 32'd0);
        check("rst_sym_cnt", 32'(bus.sym_cnt), 32'd0);
        check("rst_sym_out", 32'(bus.sym_out), 32'd0);
        tick();

        // Basic stream: 0 | 10 | 11111 -> 1, 2, 6
        load(8'h1F);
        send_bit(1'b0); exp_q.push_back(3'd1);
        send_bit(1'b1);
        send_bit(1'b0); exp_q.push_back(3'd2);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b1); exp_q.push_back(3'd6);
        drain();
        exp_cnt = exp_cnt + 16'd3;
        @(negedge clk);
        check("basic_sym_cnt", 32'(bus.sym_cnt), 32'(exp_cnt));
        check("basic_err", 32'(bus.err), 32'd0);
        tick();

        // Latency: one-bit code, back-to-back request
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd1);
        bus.bit_in = 1'b0;
        bus.bit_valid = 1'b1;
        @(negedge clk);
        check("lat_ready_t", 32'(bus.bit_ready), 32'd1);
        tick();
        @(negedge clk);
        check("lat_valid_t1", 32'(bus.sym_valid), 32'd1);
        check("lat_sym_t1", 32'(bus.sym_out), 32'd1);
        check("lat_ready_t1", 32'(bus.bit_ready), 32'd0);
        tick();
        @(negedge clk);
        check("lat_ready_t2", 32'(bus.bit_ready), 32'd1);
        tick();
        bus.bit_valid = 1'b0;
        @(negedge clk);
        check("lat_valid_t3", 32'(bus.sym_valid), 32'd1);
        drain();
        exp_cnt = exp_cnt + 16'd2;

        // Backpressure on "110" -> 3
        bus.sym_ready = 1'b0;
        send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b0); exp_q.push_back(3'd3);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_sym_out", 32'(bus.sym_out), 32'd3);
          check("bp_sym_valid", 32'(bus.sym_valid), 32'd1);
          check("bp_bit_ready", 32'(bus.bit_ready), 32'd0);
          check("bp_sym_cnt", 32'(bus.sym_cnt), 32'(exp_cnt));
          tick();
        end
        bus.sym_ready = 1'b1;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        check("bp_cnt_after", 32'(bus.sym_cnt), 32'(exp_cnt));
        check("bp_valid_after", 32'(bus.sym_valid), 32'd0);
        tick();

        // Error: symbol 6 unused, eight 1s never match
        load(8'h00);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        @(negedge clk);
        check("err_set", 32'(bus.err), 32'd1);
        check("err_bit_ready", 32'(bus.bit_ready), 32'd0);
        check("err_no_sym", 32'(bus.sym_valid), 32'd0);
        bus.bit_valid = 1'b1;
        repeat (3) begin
          tick();
          @(negedge clk);
          check("err_hold_ready", 32'(bus.bit_ready), 32'd0);
          check("err_hold", 32'(bus.err), 32'd1);
        end
        bus.bit_valid = 1'b0;
        tick();
        load(8'h1F);
        @(negedge clk);
        check("err_cleared", 32'(bus.err), 32'd0);
        check("err_cnt_cleared", 32'(bus.sym_cnt), 32'd0);
        tick();
        send_bit(1'b1);
        send_bit(1'b0); exp_q.push_back(3'd2);
        drain();

        // Reload in the middle of a code
        send_bit(1'b1); send_bit(1'b1);
        bus.bit_in = 1'b1;
        bus.bit_valid = 1'b1;
        load(8'h1F);
        bus.bit_valid = 1'b0;
        send_bit(1'b0); exp_q.push_back(3'd1);
        drain();
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        check("reload_cnt", 32'(bus.sym_cnt), 32'(exp_cnt));
        tick();

        // Reset while a symbol is pending
        bus.sym_ready = 1'b0;
        send_bit(1'b0);
        @(negedge clk);
        check("pre_rst_valid", 32'(bus.sym_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.sym_valid), 32'd0);
        check("mid_rst_cnt", 32'(bus.sym_cnt), 32'd0);
        bus.sym_ready = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_in = 1'b0;
        repeat (3) begin
          tick();
          @(negedge clk);
          check("idle_ready", 32'(bus.bit_ready), 32'd0);
          check("idle_no_sym", 32'(bus.sym_valid), 32'd0);
        end
        bus.bit_valid = 1'b0;
        tick();
        load(8'h1F);
        send_bit(1'b0); exp_q.push_back(3'd1);
        drain();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        done = 1'b1;
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
